// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op encoding, FSM states,
// exception bit positions and op classification helpers.
package mem_stage_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    // Bit positions inside addr_exc = {load_misaligned, store_misaligned}
    localparam int EXC_LOAD  = 1;
    localparam int EXC_STORE = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: load extract/extend, store strobe/replication and
// misalignment detection. Purely combinational.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        mem_op,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic              is_load,
    output logic              is_store,
    output logic              misaligned,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign is_load  = op_is_load(mem_op);
    assign is_store = op_is_store(mem_op);

    // Lane selection and sign/zero extension of returned load data
    always_comb begin
        byte_s    = rdata[{lane, 3'b000} +: 8];
        half_s    = rdata[{lane[1], 4'b0000} +: 16];
        load_data = rdata;
        case (mem_op)
            OP_LB:   load_data = DATA_W'(byte_s);
            OP_LBU:  load_data = DATA_W'($unsigned(byte_s));
            OP_LH:   load_data = DATA_W'(half_s);
            OP_LHU:  load_data = DATA_W'($unsigned(half_s));
            default: load_data = rdata;
        endcase
    end

    // Store byte enables, lane-replicated write data and alignment check
    always_comb begin
        wstrb      = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        case (mem_op)
            OP_SB: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                wstrb      = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = lane[0];
            end
            OP_SW: begin
                wstrb      = 4'b1111;
                misaligned = |lane;
            end
            OP_LH, OP_LHU: misaligned = lane[0];
            OP_LW:         misaligned = |lane;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory request per aligned load/store,
// traps misaligned accesses without touching memory, passes other ops through.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_valid,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] exe_result,
    input  logic              mem_cancel,
    input  logic              next_allow_in,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] mem_result,
    output logic [1:0]        addr_exc,
    output logic              MEM_over
);

    state_t            state_p1;
    logic [DATA_W-1:0] result_p1;
    logic              over_p1;

    logic              is_load, is_store, misaligned;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] wdata, load_data;
    logic              idle, pass_op, bad_op, mem_op_ok, req_phase;

    mem_align #(.DATA_W(DATA_W)) u_align (
        .mem_op     (mem_op),
        .lane       (mem_addr[1:0]),
        .store_data (store_data),
        .rdata      (dm_rdata),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    assign idle      = (state_p1 == S_IDLE);
    assign pass_op   = MEM_valid & ~(is_load | is_store);
    assign bad_op    = MEM_valid & (is_load | is_store) & misaligned;
    assign mem_op_ok = MEM_valid & (is_load | is_store) & ~misaligned;

    // Request is Mealy: raised from IDLE on the same cycle, held through REQ,
    // and always dropped while a flush is in flight.
    assign req_phase = (idle & mem_op_ok) | (state_p1 == S_REQ);
    assign dm_req    = req_phase & ~mem_cancel;
    assign dm_wr     = dm_req & is_store;
    assign dm_addr   = dm_req ? {mem_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dm_wstrb  = (dm_req & is_store) ? wstrb : 4'b0000;
    assign dm_wdata  = (dm_req & is_store) ? wdata : '0;

    // Pass-through and misaligned ops complete in zero cycles from IDLE
    assign MEM_over   = over_p1 | (idle & (pass_op | bad_op));
    assign mem_result = (idle & pass_op) ? exe_result :
                        (idle & bad_op)  ? DATA_W'(mem_addr) : result_p1;

    // Misalignment flags, reported only while the faulting op is presented
    always_comb begin
        addr_exc = 2'b00;
        if (idle && bad_op) begin
            addr_exc[EXC_LOAD]  = is_load;
            addr_exc[EXC_STORE] = is_store;
        end
    end

    // Transaction FSM with registered result and completion flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1  <= S_IDLE;
            result_p1 <= '0;
            over_p1   <= 1'b0;
        end else begin
            case (state_p1)
                S_IDLE, S_REQ: begin
                    if (mem_cancel) begin
                        state_p1 <= (state_p1 == S_REQ && dm_ack && is_load) ? S_DRAIN : S_IDLE;
                    end else if (req_phase) begin
                        if (dm_ack) begin
                            if (is_store) begin
                                state_p1  <= S_DONE;
                                result_p1 <= exe_result;
                                over_p1   <= 1'b1;
                            end else begin
                                state_p1 <= S_WAIT;
                            end
                        end else begin
                            state_p1 <= S_REQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (dm_rvalid) begin
                        if (mem_cancel) begin
                            state_p1 <= S_IDLE;
                        end else begin
                            state_p1  <= S_DONE;
                            result_p1 <= load_data;
                            over_p1   <= 1'b1;
                        end
                    end else if (mem_cancel) begin
                        state_p1 <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (mem_cancel || next_allow_in) begin
                        state_p1 <= S_IDLE;
                        over_p1  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (dm_rvalid) state_p1 <= S_IDLE;
                end
                default: begin
                    state_p1 <= S_IDLE;
                    over_p1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions
// compared against a transaction-level arithmetic model.
module tb_mem_stage;

    localparam int OP_NONE = 0, OP_LB = 1, OP_LBU = 2, OP_LH = 3, OP_LHU = 4;
    localparam int OP_LW = 5, OP_SB = 6, OP_SH = 7, OP_SW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, store_data, exe_result;
    logic        mem_cancel, next_allow_in;
    logic        dm_req, dm_wr;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack, dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] mem_result;
    logic [1:0]  addr_exc;
    logic        MEM_over;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .mem_op(mem_op),
        .mem_addr(mem_addr), .store_data(store_data), .exe_result(exe_result),
        .mem_cancel(mem_cancel), .next_allow_in(next_allow_in),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .mem_result(mem_result), .addr_exc(addr_exc),
        .MEM_over(MEM_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input int op);
        return op >= OP_LB && op <= OP_LW;
    endfunction

    function automatic bit m_is_store(input int op);
        return op >= OP_SB && op <= OP_SW;
    endfunction

    function automatic int unsigned m_size(input int op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 1;
        endcase
    endfunction

    function automatic bit m_misaligned(input int op, input logic [31:0] a);
        return (m_is_load(op) || m_is_store(op)) && ((a % m_size(op)) != 0);
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int unsigned sh;
        v = longint'(rd);
        case (op)
            OP_LB, OP_LBU: begin
                sh = 8 * (a % 4);
                v = longint'((rd >> sh) % 256);
                if (op == OP_LB && v >= 128) v = v - 256;
            end
            OP_LH, OP_LHU: begin
                sh = 16 * ((a % 4) / 2);
                v = longint'((rd >> sh) % 65536);
                if (op == OP_LH && v >= 32768) v = v - 65536;
            end
            default: ;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_wstrb(input int op, input logic [31:0] a);
        case (op)
            OP_SB:   return 4'(1 << (a % 4));
            OP_SH:   return 4'(3 << (2 * ((a % 4) / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] sd);
        case (op)
            OP_SB:   return 32'h0101_0101 * (sd % 256);
            OP_SH:   return 32'h0001_0001 * (sd % 65536);
            default: return sd;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic chk_zero(input string tag);
        chk({tag, " dm_req"},     32'(dm_req),     32'd0);
        chk({tag, " dm_wr"},      32'(dm_wr),      32'd0);
        chk({tag, " dm_addr"},    dm_addr,         32'd0);
        chk({tag, " dm_wstrb"},   32'(dm_wstrb),   32'd0);
        chk({tag, " dm_wdata"},   dm_wdata,        32'd0);
        chk({tag, " mem_result"}, mem_result,      32'd0);
        chk({tag, " addr_exc"},   32'(addr_exc),   32'd0);
        chk({tag, " MEM_over"},   32'(MEM_over),   32'd0);
    endtask

    // One transaction from IDLE. Cycle 0 is the first cycle the op is presented.
    // Memory acks at cycle ack_dly; load data returns rv_dly cycles after the
    // cycle following the ack. Write-back stalls hold_n cycles once complete.
    task automatic run_txn(input string tag, input int op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] exe, input logic [31:0] rd,
                           input int ack_dly, input int rv_dly, input int hold_n,
                           output int over_cyc, output int req_cnt);
        bit          mem, over_seen, fin, release_wb;
        int          ack_at, rv_at, exp_over, held;
        logic [31:0] exp_res, res_first;
        logic [1:0]  exp_exc;
        mem      = (m_is_load(op) || m_is_store(op)) && !m_misaligned(op, addr);
        ack_at   = ack_dly;
        rv_at    = ack_dly + 1 + rv_dly;
        exp_over = !mem ? 0 : (m_is_store(op) ? ack_dly + 1 : ack_dly + rv_dly + 2);
        exp_res  = m_misaligned(op, addr) ? addr : (m_is_load(op) ? m_load(op, addr, rd) : exe);
        exp_exc  = !m_misaligned(op, addr) ? 2'b00 : (m_is_load(op) ? 2'b10 : 2'b01);
        MEM_valid = 1'b1; mem_op = 4'(op); mem_addr = addr; store_data = sd; exe_result = exe;
        over_cyc = -1; req_cnt = 0; over_seen = 0; fin = 0; held = 0; res_first = '0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            dm_ack        = mem && (cyc == ack_at);
            dm_rvalid     = mem && m_is_load(op) && (cyc == rv_at);
            dm_rdata      = (cyc == rv_at) ? rd : $urandom;
            release_wb    = (held >= hold_n);
            next_allow_in = release_wb;
            #1;
            if (!over_seen) begin
                chk({tag, " dm_req"}, 32'(dm_req), 32'(mem && cyc <= ack_at));
                if (dm_req) begin
                    req_cnt++;
                    chk({tag, " dm_addr"}, dm_addr, {addr[31:2], 2'b00});
                    chk({tag, " dm_wr"}, 32'(dm_wr), 32'(m_is_store(op)));
                    if (m_is_store(op)) begin
                        chk({tag, " dm_wstrb"}, 32'(dm_wstrb), 32'(m_wstrb(op, addr)));
                        chk({tag, " dm_wdata"}, dm_wdata, m_wdata(op, sd));
                    end
                end
                if (MEM_over) begin
                    over_seen = 1;
                    over_cyc  = cyc;
                    res_first = mem_result;
                    chk({tag, " over_cycle"}, 32'(cyc), 32'(exp_over));
                    chk({tag, " addr_exc"}, 32'(addr_exc), 32'(exp_exc));
                    if (!m_is_store(op) || !mem)
                        chk({tag, " mem_result"}, mem_result, exp_res);
                end
            end else begin
                chk({tag, " hold MEM_over"}, 32'(MEM_over), 32'd1);
                chk({tag, " hold mem_result"}, mem_result, res_first);
                chk({tag, " hold dm_req"}, 32'(dm_req), 32'd0);
            end
            if (over_seen) begin
                if (release_wb) fin = 1;
                else held++;
            end
            @(posedge clk); #1;
        end
        chk({tag, " completed"}, 32'(over_seen), 32'd1);
        MEM_valid = 1'b0; mem_op = 4'd0; dm_ack = 1'b0; dm_rvalid = 1'b0; next_allow_in = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int oc, rc, op, ad, rv, hd;
        logic [31:0] addr;
        reset = 1'b1; MEM_valid = 0; mem_op = 0; mem_addr = 0; store_data = 0;
        exe_result = 0; mem_cancel = 0; next_allow_in = 0; dm_ack = 0; dm_rvalid = 0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Stray read data while idle must not complete anything
        dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dm_rvalid = 1'b0; #1;
        chk("stray rvalid MEM_over", 32'(MEM_over), 32'd0);
        chk("stray rvalid mem_result", mem_result, 32'd0);
        @(posedge clk); #1;

        run_txn("lb", OP_LB, 32'h0000_1003, 32'h0, 32'h5555_5555, 32'h80FF_1234, 0, 0, 0, oc, rc);
        #1;
        chk("lb over_cycle", 32'(oc), 32'd2);
        chk("lb result", mem_result, 32'hFFFF_FF80);

        run_txn("sh", OP_SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0, 0, 0, 0, oc, rc);
        chk("sh over_cycle", 32'(oc), 32'd1);
        chk("sh req_cycles", 32'(rc), 32'd1);

        run_txn("lw mis", OP_LW, 32'h0000_3001, 32'h0, 32'h0, 32'h0, 0, 0, 0, oc, rc);
        chk("lw mis over_cycle", 32'(oc), 32'd0);
        chk("lw mis req_cycles", 32'(rc), 32'd0);

        run_txn("lhu", OP_LHU, 32'h0000_4002, 32'h0, 32'h0, 32'hBEEF_0000, 3, 1, 0, oc, rc);
        #1;
        chk("lhu req_cycles", 32'(rc), 32'd4);
        chk("lhu over_cycle", 32'(oc), 32'd6);
        chk("lhu result", mem_result, 32'h0000_BEEF);

        // Cancel while waiting for load data: drain absorbs the late response
        MEM_valid = 1; mem_op = 4'(OP_LW); mem_addr = 32'h0000_5000; dm_ack = 1; next_allow_in = 1;
        #1;
        chk("cancel req", 32'(dm_req), 32'd1);
        @(posedge clk); #1;
        dm_ack = 0; mem_cancel = 1;
        #1;
        chk("cancel wait MEM_over", 32'(MEM_over), 32'd0);
        chk("cancel wait dm_req", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        mem_cancel = 0; mem_op = 4'(OP_NONE); exe_result = 32'h0BAD_F00D;
        #1;
        chk("drain MEM_over", 32'(MEM_over), 32'd0);
        @(posedge clk); #1;
        dm_rvalid = 1; dm_rdata = 32'h1234_5678;
        #1;
        chk("drain rvalid MEM_over", 32'(MEM_over), 32'd0);
        @(posedge clk); #1;
        dm_rvalid = 0;
        #1;
        chk("after drain MEM_over", 32'(MEM_over), 32'd1);
        chk("after drain pass result", mem_result, 32'h0BAD_F00D);
        MEM_valid = 0;
        #1;
        chk("drain kept result", mem_result, 32'h0000_BEEF);
        @(posedge clk); #1;
        run_txn("sw after cancel", OP_SW, 32'h0000_5004, 32'hCAFE_1234, 32'h0, 32'h0, 0, 0, 0, oc, rc);
        chk("sw after cancel over_cycle", 32'(oc), 32'd1);

        run_txn("lbu hold", OP_LBU, 32'h0000_6001, 32'h0, 32'h0, 32'hA5C3_7E19, 1, 0, 5, oc, rc);
        chk("lbu hold over_cycle", 32'(oc), 32'd3);

        // Asynchronous reset in the middle of a load
        MEM_valid = 1; mem_op = 4'(OP_LH); mem_addr = 32'h0000_7002; dm_ack = 1; next_allow_in = 1;
        @(posedge clk); #1;
        dm_ack = 0;
        #2;
        reset = 1; MEM_valid = 0;
        #1;
        chk_zero("async reset");
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        run_txn("lh after reset", OP_LH, 32'h0000_7002, 32'h0, 32'h0, 32'h8001_7FFF, 0, 0, 0, oc, rc);
        chk("lh after reset over_cycle", 32'(oc), 32'd2);

        // Randomized transactions, opcodes 9..15 act as pass-through
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 15));
            addr = $urandom;
            ad   = int'($urandom_range(0, 3));
            rv   = int'($urandom_range(0, 3));
            hd   = int'($urandom_range(0, 2));
            run_txn("rand", op, addr, $urandom, $urandom, $urandom, ad, rv, hd, oc, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
